fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the 16x8 FIFO between NREQ producers.
- Grants ownership round-robin. The owner streams up to BURST bytes back-to-back into the FIFO.
- Gates writes with the FIFO full flag so no byte is ever offered to the FIFO while it is full.
- Sits directly in front of the FIFO's Din/Wen/Ffull pins; producers see a per-port valid/grant handshake.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 8, data width; matches FIFO Din
- BURST, 4, max bytes per ownership tenure (1..15)

Ports:
- ck  in  1  clock, rising edge
- rst  in  1  reset: synchronous, active-low
- req  in  NREQ  per-requester valid; held with data until granted
- din  in  NREQ*DW  requester data, requester i at bits [i*DW +: DW]
- gnt  out  NREQ  one-hot; gnt[i]=1 means din slice i is written this cycle
- fifo_din  out  DW  to FIFO Din
- fifo_wen  out  1  to FIFO Wen
- fifo_full  in  1  from FIFO Ffull
- owner  out  clog2(NREQ)  current/last owner index (debug)
- busy  out  1  1 while in state OWN

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=ARB, owner=0, rr_ptr=0, burst_cnt=0.
  - gnt, fifo_wen and busy all read 0 during the reset cycle.
  - Reset mid-burst abandons the tenure. No partial write: fifo_wen is 0 in the reset cycle.
- States:
  - ARB, one cycle per arbitration.
  - OWN.
- ARB:
  - If any req is set: owner <= first set req at or after rr_ptr, searching upward and wrapping NREQ-1 -> 0. Then burst_cnt <= 0 and state <= OWN.
  - If no req is set: stay in ARB.
  - No writes occur in ARB, so arbitration costs 1 bubble cycle per tenure.
- OWN:
  - Write condition is req[owner] && !fifo_full.
  - When the write condition holds, combinationally in the same cycle: fifo_wen=1, fifo_din=din[owner], gnt[owner]=1. Also burst_cnt <= burst_cnt+1.
  - When the write condition is false, fifo_wen=0 and gnt=0. fifo_din holds din[owner], don't-care.
  - Tenure ends (state <= ARB, rr_ptr <= owner+1 mod NREQ) on whichever comes first:
    - req[owner]=0;
    - a write that brings burst_cnt to BURST.
  - fifo_full=1 with req[owner]=1 stalls in OWN. The tenure is kept and burst_cnt is unchanged.
- Full boundary: Ffull rises the cycle after the 16th write. The gating by fifo_full is purely combinational, so the FIFO never sees Wen=1 while full.
- Producer contract: din slice stable while req=1. The producer deasserts or advances its data only after a cycle with gnt=1.
- gnt is at most one-hot. Bits for non-owners are always 0.
- Width rules:
  - burst_cnt is 4 bits.
  - rr_ptr and owner are clog2(NREQ) bits. Wrap is explicit mod NREQ, which matters for non-power-of-2 NREQ.
- Fairness bound: a requester holding req waits at most (NREQ-1)*(BURST+1) write-able cycles.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - Adds output gcount, NREQ*16 bits: per-requester count of granted bytes, saturating at 16'hFFFF.
  - Adds input stat_clr, 1 bit: a synchronous clear that zeroes all counters on the next edge. If a grant coincides with stat_clr, the clear wins.
  - Counters reset to 0 on rst=0.
- Undefined: neither port exists and there are no counter flops. All other behaviour is identical.

Decomposition:
- Package fifo_arb_pkg:
  - state enum {ARB, OWN};
  - localparams for default NREQ/DW/BURST;
  - a function returning clog2.
- Sub-module rr_pick: combinational round-robin priority picker. Inputs are req and rr_ptr; outputs are a valid flag and the chosen index. It is instantiated once in ARB, reusable by future read-side schedulers.

Test Plan:
- Reset mid-tenure: rst=0 while in OWN with req=4'b0001 -> next cycle state ARB, owner=0, no fifo_wen pulse, gnt=0.
- Single producer: req[2] held, 6 bytes 0x10..0x15, FIFO empty -> gnt[2] pulses. Writes occur as bursts of 4 then 2: ARB, 4 writes (0x10..0x13), ARB, 2 writes (0x14,0x15). Total 8 cycles, FIFO holds 6 bytes in order.
- Round-robin: req=4'b1111 held continuously, BURST=4 -> owners in order 0,1,2,3,0. Each gets exactly 4 consecutive gnt pulses separated by one ARB cycle.
- Full stall: FIFO preloaded with 14 bytes, req[1] with 4 bytes -> 2 writes, Ffull=1, fifo_wen stays 0, owner stays 1. Reader pops 1 byte -> next write resumes. No byte is lost or duplicated across 4 writes.
- Early release and wrap, NREQ=3: owner 2 drops req after 1 byte -> rr_ptr wraps to 0. Next ARB with req=3'b101 picks 0, not 2.
- ARB_STATS_EN: 20 grants to requester 3, then stat_clr=1 on a grant cycle -> gcount slice 3 reads 20 before the clear edge and 0 after it.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared types, defaults and clog2 helper for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic {ARB = 1'b0, OWN = 1'b1} arb_state_t;

  localparam int NREQ_DEF  = 4;
  localparam int DW_DEF    = 8;
  localparam int BURST_DEF = 4;

  // Never returns less than 1 so single-bit indices stay legal for NREQ=2.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin picker: first set req at or after ptr, wrapping
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int  NREQ = NREQ_DEF,
  localparam int W    = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [W-1:0]    ptr,
  output logic            valid,
  output logic [W-1:0]    idx
);

  logic [W-1:0] j;

  // Walk the ring backwards so the candidate closest to ptr is written last and wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = W'((int'(ptr) + k) % NREQ);
      if (req[j]) begin
        valid = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin, burst-limited arbiter for the 16x8 FIFO write port
// Optional per-requester grant counters under ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int  NREQ  = NREQ_DEF,
  parameter int  DW    = DW_DEF,
  parameter int  BURST = BURST_DEF,
  localparam int W     = clog2(NREQ)
) (
  input  logic              ck,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] din,
  output logic [NREQ-1:0]   gnt,
  output logic [DW-1:0]     fifo_din,
  output logic              fifo_wen,
  input  logic              fifo_full,
  output logic [W-1:0]      owner,
  output logic              busy
`ifdef ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [NREQ*16-1:0] gcount
`endif
);

  localparam logic [3:0]   BURST_L = 4'(BURST);
  localparam logic [W-1:0] LAST    = W'(NREQ - 1);

  arb_state_t   state, state_nx;
  logic [W-1:0] owner_nx, rr_ptr, rr_ptr_nx, pick_idx;
  logic [3:0]   burst_cnt, burst_cnt_nx;
  logic         pick_valid, req_own, wr;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    req_own  = 1'b0;
    fifo_din = din[DW-1:0];
    for (int i = 0; i < NREQ; i++) begin
      if (owner == W'(i)) begin
        req_own  = req[i];
        fifo_din = din[i*DW +: DW];
      end
    end
  end

  // Qualified by rst so a reset cycle can never leak a partial write.
  assign wr       = rst && (state == OWN) && req_own && !fifo_full;
  assign fifo_wen = wr;
  assign busy     = rst && (state == OWN);

  always_comb begin
    gnt = '0;
    for (int i = 0; i < NREQ; i++) gnt[i] = wr && (owner == W'(i));
  end

  always_ff @(posedge ck) begin
    if (!rst) begin
      state     <= ARB;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nx;
      owner     <= owner_nx;
      rr_ptr    <= rr_ptr_nx;
      burst_cnt <= burst_cnt_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    owner_nx     = owner;
    rr_ptr_nx    = rr_ptr;
    burst_cnt_nx = burst_cnt;
    case (state)
      ARB: begin
        if (pick_valid) begin
          state_nx     = OWN;
          owner_nx     = pick_idx;
          burst_cnt_nx = '0;
        end
      end
      OWN: begin
        if (wr) burst_cnt_nx = burst_cnt + 4'd1;
        if (!req_own || (wr && (burst_cnt + 4'd1 == BURST_L))) begin
          state_nx  = ARB;
          rr_ptr_nx = (owner == LAST) ? '0 : owner + W'(1);
        end
      end
      default: state_nx = ARB;
    endcase
  end

`ifdef ARB_STATS_EN
  logic [15:0] cnt [NREQ];

  // Clear has priority over a coincident grant.
  always_ff @(posedge ck) begin
    for (int i = 0; i < NREQ; i++) begin
      if (!rst || stat_clr)
        cnt[i] <= '0;
      else if (gnt[i] && (cnt[i] != 16'hFFFF))
        cnt[i] <= cnt[i] + 16'd1;
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_gcount
    assign gcount[g*16 +: 16] = cnt[g];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter against a cycle reference model
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int BURST = 4;

  logic        ck = 1'b0;
  always #5 ck = ~ck;

  logic        rst;
  logic [3:0]  req;
  logic [31:0] din;
  logic        fifo_full;
  logic [3:0]  gnt;
  logic [7:0]  fifo_din;
  logic        fifo_wen;
  logic [1:0]  owner;
  logic        busy;

  logic        rst3;
  logic [2:0]  req3;
  logic [23:0] din3;
  logic [2:0]  gnt3;
  logic [7:0]  fifo_din3;
  logic        fifo_wen3;
  logic [1:0]  owner3;
  logic        busy3;

`ifdef ARB_STATS_EN
  logic        stat_clr;
  logic        stat_clr3;
  logic [63:0] gcount;
  logic [47:0] gcount3;
`endif

  fifo_wr_arbiter dut (
`ifdef ARB_STATS_EN
    .stat_clr (stat_clr),
    .gcount   (gcount),
`endif
    .ck        (ck),
    .rst       (rst),
    .req       (req),
    .din       (din),
    .gnt       (gnt),
    .fifo_din  (fifo_din),
    .fifo_wen  (fifo_wen),
    .fifo_full (fifo_full),
    .owner     (owner),
    .busy      (busy)
  );

  fifo_wr_arbiter #(.NREQ(3)) dut3 (
`ifdef ARB_STATS_EN
    .stat_clr (stat_clr3),
    .gcount   (gcount3),
`endif
    .ck        (ck),
    .rst       (rst3),
    .req       (req3),
    .din       (din3),
    .gnt       (gnt3),
    .fifo_din  (fifo_din3),
    .fifo_wen  (fifo_wen3),
    .fifo_full (1'b0),
    .owner     (owner3),
    .busy      (busy3)
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model: tenure-level view of who owns the port and how much it has written.
  bit m_own;
  int m_owner, m_ptr, m_cnt;

  logic [7:0] pq [4][$];
  logic [7:0] fq [$];
  logic [7:0] wl1 [$];
  int         gseq [$];
  int         rd_mode, wcnt, g3cnt;
  logic [3:0] o_gnt;
  logic       o_wen, o_busy;
  logic [1:0] o_owner;
  logic [7:0] o_din;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req[i]          = (pq[i].size() != 0);
      din[i*8 +: 8]   = (pq[i].size() != 0) ? pq[i][0] : 8'h00;
    end
    fifo_full = (fq.size() >= 16);
  endtask

  task automatic clear_world();
    for (int i = 0; i < 4; i++) pq[i].delete();
    fq.delete();
    wl1.delete();
    gseq.delete();
    wcnt = 0;
  endtask

  task automatic cycle();
    logic       ew;
    logic [3:0] eg;
    bit         rd, found;
    drive();
    @(negedge ck);
    ew = rst && m_own && req[m_owner] && !fifo_full;
    eg = ew ? 4'(1 << m_owner) : 4'b0;
    o_gnt = gnt; o_wen = fifo_wen; o_busy = busy; o_owner = owner; o_din = fifo_din;
    chk("wen", o_wen, ew);
    chk("gnt", o_gnt, eg);
    chk("busy", o_busy, rst && m_own);
    chk("owner", o_owner, m_owner);
    if (ew) chk("data", o_din, pq[m_owner][0]);
    rd = (rd_mode == 1) || (rd_mode == 2 && $urandom_range(1) == 1);
    @(posedge ck);
    for (int i = 0; i < 4; i++) begin
      if (o_gnt[i] && pq[i].size() != 0) begin
        gseq.push_back(i);
        if (i == 1) wl1.push_back(o_din);
        if (i == 3) g3cnt++;
        void'(pq[i].pop_front());
      end
    end
    if (rd && fq.size() != 0) void'(fq.pop_front());
    if (o_wen) begin
      fq.push_back(o_din);
      wcnt++;
    end
    if (!rst) begin
      m_own = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    end else if (!m_own) begin
      found = 0;
      for (int k = 0; k < NREQ; k++) begin
        if (req[(m_ptr + k) % NREQ]) begin
          m_owner = (m_ptr + k) % NREQ;
          found   = 1;
          break;
        end
      end
      if (found) begin
        m_own = 1;
        m_cnt = 0;
      end
    end else begin
      if (ew) m_cnt++;
      if (!req[m_owner] || m_cnt == BURST) begin
        m_own = 0;
        m_ptr = (m_owner + 1) % NREQ;
      end
    end
    #1;
  endtask

  initial begin
    int total;
    rd_mode = 0; rst = 0; req = '0; din = '0; fifo_full = 0;
    rst3 = 0; req3 = '0; din3 = '0;
    m_own = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; g3cnt = 0;
`ifdef ARB_STATS_EN
    stat_clr = 0; stat_clr3 = 0;
`endif
    clear_world();

    // NREQ=3: owner 2 releases after one byte, pointer wraps, 3'b101 goes to 0.
    repeat (2) @(posedge ck);
    #1 rst3 = 1; req3 = 3'b100; din3 = {8'h5A, 8'h00, 8'h00};
    @(negedge ck); chk("n3_arb_busy", busy3, 0); chk("n3_arb_gnt", gnt3, 0);
    @(posedge ck); #1;
    @(negedge ck); chk("n3_gnt2", gnt3, 3'b100); chk("n3_din2", fifo_din3, 8'h5A); chk("n3_owner2", owner3, 2);
    @(posedge ck); #1 req3 = 3'b000;
    @(negedge ck); chk("n3_release_gnt", gnt3, 0); chk("n3_release_busy", busy3, 1);
    @(posedge ck); #1 req3 = 3'b101; din3 = {8'h03, 8'h00, 8'h01};
    @(negedge ck); chk("n3_rearb_busy", busy3, 0);
    @(posedge ck); #1;
    @(negedge ck); chk("n3_owner0", owner3, 0); chk("n3_gnt0", gnt3, 3'b001); chk("n3_din0", fifo_din3, 8'h01);
    @(posedge ck); #1 req3 = 3'b000;

    // Reset state
    rst = 0;
    cycle(); cycle();
    chk("rst_gnt", o_gnt, 0); chk("rst_wen", o_wen, 0); chk("rst_busy", o_busy, 0); chk("rst_owner", o_owner, 0);
    rst = 1;

    // Single producer, 6 bytes -> ARB, 4 writes, ARB, 2 writes in 8 cycles.
    for (int b = 0; b < 6; b++) pq[2].push_back(8'(8'h10 + b));
    repeat (8) cycle();
    chk("single_writes", wcnt, 6);
    chk("single_depth", fq.size(), 6);
    for (int k = 0; k < 6 && k < fq.size(); k++) chk("single_order", fq[k], 8'(8'h10 + k));

    // Reset mid-tenure
    rst = 0; cycle(); rst = 1; clear_world();
    for (int b = 0; b < 3; b++) pq[0].push_back(8'(8'hA0 + b));
    rd_mode = 1;
    cycle(); cycle();
    chk("mid_pre_wen", o_wen, 1);
    rst = 0; cycle();
    chk("mid_rst_wen", o_wen, 0); chk("mid_rst_gnt", o_gnt, 0);
    rst = 1; cycle();
    chk("mid_post_busy", o_busy, 0); chk("mid_post_owner", o_owner, 0);
    repeat (6) cycle();

    // Round robin, all four requesting
    rst = 0; cycle(); rst = 1; clear_world();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 8; k++) pq[i].push_back(8'(i * 16 + k));
    repeat (25) cycle();
    chk("rr_count", gseq.size(), 20);
    for (int k = 0; k < 20 && k < gseq.size(); k++) chk("rr_owner", gseq[k], (k / 4) % 4);
    repeat (20) cycle();

    // Full stall: 14 preloaded, requester 1 with 4 bytes
    rst = 0; cycle(); rst = 1; clear_world();
    for (int k = 0; k < 14; k++) fq.push_back(8'(8'hE0 + k));
    for (int b = 0; b < 4; b++) pq[1].push_back(8'(8'hB0 + b));
    rd_mode = 0;
    repeat (5) cycle();
    chk("full_writes", wcnt, 2);
    chk("full_stall_wen", o_wen, 0); chk("full_stall_busy", o_busy, 1); chk("full_stall_owner", o_owner, 1);
    rd_mode = 1; cycle(); rd_mode = 0;
    cycle();
    chk("full_resume", o_wen, 1);
    rd_mode = 1;
    repeat (6) cycle();
    chk("full_total", wl1.size(), 4);
    for (int k = 0; k < 4 && k < wl1.size(); k++) chk("full_data", wl1[k], 8'(8'hB0 + k));

`ifdef ARB_STATS_EN
    // 20 grants to requester 3, then clear on a grant cycle
    rst = 0; cycle(); rst = 1; clear_world();
    for (int k = 0; k < 24; k++) pq[3].push_back(8'(k));
    g3cnt = 0;
    for (int n = 0; n < 60 && g3cnt < 20; n++) cycle();
    chk("stat_reach", g3cnt, 20);
    cycle();
    chk("stat_pre", gcount[63:48], 20);
    stat_clr = 1; cycle(); stat_clr = 0;
    chk("stat_clr_grant", o_gnt, 4'b1000);
    chk("stat_post", gcount[63:48], 0);
`endif

    // Randomized traffic with random reader and sparse resets
    rst = 0; cycle(); rst = 1; clear_world();
    rd_mode = 2;
    repeat (800) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(3) == 0 && pq[i].size() < 6) pq[i].push_back(8'($urandom));
      rst = ($urandom_range(99) != 0);
      cycle();
    end
    rst = 1; rd_mode = 1;
    total = 0;
    for (int i = 0; i < 4; i++) total += pq[i].size();
    for (int n = 0; n < 400 && total != 0; n++) begin
      cycle();
      total = 0;
      for (int i = 0; i < 4; i++) total += pq[i].size();
    end
    chk("drain", total, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
